// File: rtl/power_ctl.sv
// Turn and throw-power controller: ramps a bouncing 5-bit charge while fire is held,
// strobes a launch on release, then hands the turn over after the projectile resolves.
package variable_pkg;
  localparam logic [1:0] PLAYER_1 = 2'b01;
  localparam logic [1:0] PLAYER_2 = 2'b10;
endpackage

module power_ctl
  import variable_pkg::*;
#(
  parameter int unsigned STEP_CYCLES    = 1_000_000,
  parameter int unsigned FLIGHT_TIMEOUT = 300_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       fire_btn,
  input  logic       hit_done,
  output logic [4:0] power,
  output logic [1:0] current_player,
  output logic       charging,
  output logic       launch,
  output logic [4:0] launch_power
);

  localparam int unsigned PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned TO_W  = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FLIGHT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    FIRE   = 3'd2,
    FLIGHT = 3'd3,
    SWITCH = 3'd4
  } state_t;

  state_t           state_q;
  logic             btn_q;
  logic             dir_up_q;
  logic [PRE_W-1:0] pre_q;
  logic [TO_W-1:0]  to_q;

  logic       press;
  logic       tick;
  logic       timeout;
  logic [4:0] power_d;
  logic       dir_up_d;

  assign press   = fire_btn & ~btn_q;
  assign tick    = (pre_q == PRE_LAST);
  assign timeout = (to_q == TO_LAST);

  // Next charge level: the direction flips on the step that lands on an endpoint,
  // so neither 0 nor 31 is ever emitted twice in a row.
  always_comb begin
    power_d  = power;
    dir_up_d = dir_up_q;
    if (dir_up_q) begin
      power_d = power + 5'd1;
      if (power == 5'd30) begin
        dir_up_d = 1'b0;
      end else begin
        dir_up_d = 1'b1;
      end
    end else begin
      power_d = power - 5'd1;
      if (power == 5'd1) begin
        dir_up_d = 1'b1;
      end else begin
        dir_up_d = 1'b0;
      end
    end
  end

  // Turn FSM with registered outputs; counters clear on every state change.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q        <= IDLE;
      btn_q          <= 1'b0;
      dir_up_q       <= 1'b1;
      pre_q          <= {PRE_W{1'b0}};
      to_q           <= {TO_W{1'b0}};
      power          <= 5'd0;
      current_player <= PLAYER_1;
      charging       <= 1'b0;
      launch         <= 1'b0;
      launch_power   <= 5'd0;
    end else begin
      btn_q  <= fire_btn;
      launch <= 1'b0;
      case (state_q)
        IDLE: begin
          power    <= 5'd0;
          charging <= 1'b0;
          if (press) begin
            state_q  <= CHARGE;
            charging <= 1'b1;
            dir_up_q <= 1'b1;
            pre_q    <= {PRE_W{1'b0}};
            to_q     <= {TO_W{1'b0}};
          end
        end
        CHARGE: begin
          // Release takes priority over a coincident tick: the pending step is dropped.
          if (!fire_btn) begin
            state_q      <= FIRE;
            charging     <= 1'b0;
            launch       <= 1'b1;
            launch_power <= power;
            pre_q        <= {PRE_W{1'b0}};
            to_q         <= {TO_W{1'b0}};
          end else if (tick) begin
            pre_q    <= {PRE_W{1'b0}};
            power    <= power_d;
            dir_up_q <= dir_up_d;
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
        FIRE: begin
          state_q <= FLIGHT;
          pre_q   <= {PRE_W{1'b0}};
          to_q    <= {TO_W{1'b0}};
        end
        FLIGHT: begin
          if (hit_done || timeout) begin
            state_q <= SWITCH;
            pre_q   <= {PRE_W{1'b0}};
            to_q    <= {TO_W{1'b0}};
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        SWITCH: begin
          current_player <= (current_player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
          power          <= 5'd0;
          state_q        <= IDLE;
          pre_q          <= {PRE_W{1'b0}};
          to_q           <= {TO_W{1'b0}};
        end
        default: begin
          state_q  <= IDLE;
          power    <= 5'd0;
          charging <= 1'b0;
          pre_q    <= {PRE_W{1'b0}};
          to_q     <= {TO_W{1'b0}};
        end
      endcase
    end
  end

endmodule
